flag_cond_reader: RTL and testbench

//  Read side of the ZCSO flag register: evaluates branch/jump condition codes against stored flags.

---
 rtl/flag_cond_reader.sv | 167 ++++++++++++++++
 tb/tb_flag_cond_reader.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_cond_reader.sv
// -----------------------------------------------------------------------------
// flag_cond_reader
//
// Read side of the ZCSO flag register. Accepts one branch request at a time,
// reads the flags through the flag register's registered read port, evaluates
// the condition code, and returns taken/not-taken together with the target.
// A saturating counter tracks how many taken results were handed over.
//
// Build option: FLAG_BYPASS_EN
//   defined   - a flag write that coincides with the CAPTURE cycle is merged
//               into the sampled flags (no stall).
//   undefined - such a sample is discarded and the flags are read again.
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous, active-low reset
//   req_valid/req_ready/req_cond/req_target   branch request handshake
//   flag_rd_en     read strobe to the flag register
//   flag_rd_data   {O,S,C,Z}, valid the cycle after flag_rd_en
//   flag_wr_en/flag_wr_mask/flag_wr_data      ALU flag write in progress
//   res_valid/res_ready/res_taken/res_target  result handshake
//   cnt_clear      synchronous clear of taken_count (wins over increment)
//   taken_count    saturating count of accepted taken results
// -----------------------------------------------------------------------------
module flag_cond_reader #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_cond,
    input  logic [ADDR_W-1:0] req_target,
    output logic              flag_rd_en,
    input  logic [3:0]        flag_rd_data,
    input  logic              flag_wr_en,
    input  logic [3:0]        flag_wr_mask,
    input  logic [3:0]        flag_wr_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_taken,
    output logic [ADDR_W-1:0] res_target,
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  taken_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic               req_ready_reg;
    logic               flag_rd_en_reg;
    logic               res_valid_reg;
    logic               res_taken_reg;
    logic [3:0]         cond_reg;
    logic [3:0]         flags_reg;
    logic [ADDR_W-1:0]  target_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [3:0]         eff_flags;
    logic               cond_true;

    // Codes come in complementary pairs (1/2, 3/4, ... 9/A, B/C, D/E, F/0):
    // the odd code is the true sense, the following even code its inverse.
    // Code 0 ("always") is the inverse of F ("never") through 4-bit wrap.
    function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] flags);
        logic       z, c, s, o;
        logic       base;
        logic [3:0] pair;
        {o, s, c, z} = flags;
        pair = cond[0] ? cond : cond - 4'd1;
        case (pair)
            4'h1:    base = z;
            4'h3:    base = c;
            4'h5:    base = s;
            4'h7:    base = o;
            4'h9:    base = (s == o);
            4'hB:    base = !z && (s == o);
            4'hD:    base = c && !z;
            default: base = 1'b0;       // 4'hF, never
        endcase
        return cond[0] ? base : !base;
    endfunction

`ifdef FLAG_BYPASS_EN
    // Forward an in-flight write over the registered read data.
    assign eff_flags = flag_wr_en ? ((flag_rd_data & ~flag_wr_mask) | (flag_wr_data & flag_wr_mask))
                                  : flag_rd_data;
`else
    assign eff_flags = flag_rd_data;
    // The write payload only matters for forwarding; keep it formally consumed.
    logic unused_wr;
    assign unused_wr = ^{flag_wr_mask, flag_wr_data};
`endif

    assign cond_true = eval_cond(cond_reg, eff_flags);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid && req_ready_reg) state_next = READ;
            READ:    state_next = CAPTURE;
`ifdef FLAG_BYPASS_EN
            CAPTURE: state_next = RESP;
`else
            // A concurrent write makes the sample stale: read again.
            CAPTURE: state_next = flag_wr_en ? READ : RESP;
`endif
            RESP:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake/strobe outputs are registered copies of the next state so that
    // they are glitch-free and forced low while reset is asserted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            req_ready_reg  <= 1'b0;
            flag_rd_en_reg <= 1'b0;
            res_valid_reg  <= 1'b0;
            res_taken_reg  <= 1'b0;
            cond_reg       <= '0;
            flags_reg      <= '0;
            target_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            req_ready_reg  <= (state_next == IDLE);
            flag_rd_en_reg <= (state_next == READ);
            res_valid_reg  <= (state_next == RESP);
            if (state_reg == IDLE && req_valid && req_ready_reg) begin
                cond_reg   <= req_cond;
                target_reg <= req_target;
            end
            if (state_reg == CAPTURE && state_next == RESP) begin
                flags_reg     <= eff_flags;
                res_taken_reg <= cond_true;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (cnt_clear) begin
            count_reg <= '0;
        end else if (res_valid_reg && res_ready && res_taken_reg && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Latched flags are kept for debug visibility only.
    logic unused_flags;
    assign unused_flags = ^flags_reg;

    assign req_ready   = req_ready_reg;
    assign flag_rd_en  = flag_rd_en_reg;
    assign res_valid   = res_valid_reg;
    assign res_taken   = res_taken_reg;
    assign res_target  = target_reg;
    assign taken_count = count_reg;

endmodule

// File: tb/tb_flag_cond_reader.sv
// -----------------------------------------------------------------------------
// tb_flag_cond_reader
//
// Self-checking bench for flag_cond_reader. A small flag register (registered,
// write-first read port) lives in the bench as environment. Expected results
// come from a direct truth table of the condition codes, a saturating counter
// model and the fixed request-to-result latency.
// -----------------------------------------------------------------------------
module tb_flag_cond_reader;

    localparam int ADDR_W  = 16;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    // Edges from the accept edge until res_valid is seen high: the result is
    // visible in the third cycle after the accept cycle.
    localparam int BASE_LAT = 2;
`ifdef FLAG_BYPASS_EN
    localparam int HIT_EXTRA = 0;
`else
    localparam int HIT_EXTRA = 2;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_cond;
    logic [ADDR_W-1:0] req_target;
    logic              flag_rd_en;
    logic [3:0]        flag_rd_data;
    logic              flag_wr_en;
    logic [3:0]        flag_wr_mask;
    logic [3:0]        flag_wr_data;
    logic              res_valid;
    logic              res_ready;
    logic              res_taken;
    logic [ADDR_W-1:0] res_target;
    logic              cnt_clear;
    logic [CNT_W-1:0]  taken_count;

    int tests = 0;
    int fails = 0;
    int exp_count = 0;
    logic [3:0] flag_mem = 4'h0;

    always #5 clock = ~clock;

    flag_cond_reader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cond(req_cond), .req_target(req_target),
        .flag_rd_en(flag_rd_en), .flag_rd_data(flag_rd_data),
        .flag_wr_en(flag_wr_en), .flag_wr_mask(flag_wr_mask), .flag_wr_data(flag_wr_data),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_taken(res_taken), .res_target(res_target),
        .cnt_clear(cnt_clear), .taken_count(taken_count)
    );

    // Flag register environment: registered read, write-first. When not
    // strobed the read data is garbage so a mistimed sample shows up.
    always @(posedge clock) begin
        logic [3:0] merged;
        merged = (flag_mem & ~flag_wr_mask) | (flag_wr_data & flag_wr_mask);
        if (flag_rd_en) flag_rd_data <= flag_wr_en ? merged : flag_mem;
        else            flag_rd_data <= 4'($urandom);
        if (flag_wr_en) flag_mem <= merged;
    end

    // Condition truth table, flags given as {O,S,C,Z}.
    function automatic logic ref_taken(input logic [3:0] c, input logic [3:0] f);
        logic z, cy, s, o;
        z = f[0]; cy = f[1]; s = f[2]; o = f[3];
        case (c)
            4'h0: return 1'b1;
            4'h1: return z;
            4'h2: return !z;
            4'h3: return cy;
            4'h4: return !cy;
            4'h5: return s;
            4'h6: return !s;
            4'h7: return o;
            4'h8: return !o;
            4'h9: return s == o;
            4'hA: return s != o;
            4'hB: return !z && (s == o);
            4'hC: return z || (s != o);
            4'hD: return cy && !z;
            4'hE: return !cy || z;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_flags(input logic [3:0] f);
        flag_wr_en = 1'b1; flag_wr_mask = 4'hF; flag_wr_data = f;
        @(posedge clock); #1;
        flag_wr_en = 1'b0; flag_wr_mask = 4'h0; flag_wr_data = 4'h0;
    endtask

    // Present a request, let it be accepted, and count edges until res_valid.
    task automatic send(input logic [3:0] c, input logic [ADDR_W-1:0] t, output int lat);
        int w;
        req_valid = 1'b1; req_cond = c; req_target = t; w = 0;
        while (!req_ready && w < 20) begin @(posedge clock); #1; w++; end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: req_ready=%0b required 1", req_ready);
        end
        @(posedge clock); #1;
        req_valid = 1'b0; req_cond = 4'($urandom); req_target = ADDR_W'($urandom);
        lat = 0;
        while (!res_valid && lat < 40) begin @(posedge clock); #1; lat++; end
    endtask

    // Hold res_ready low for 'stall' cycles, then complete the handshake.
    task automatic complete(input logic exp_taken, input int stall);
        res_ready = 1'b0;
        repeat (stall) begin @(posedge clock); #1; end
        res_ready = 1'b1;
        @(posedge clock); #1;
        res_ready = 1'b0;
        if (exp_taken && exp_count < CNT_MAX) exp_count++;
    endtask

    task automatic clear_count;
        cnt_clear = 1'b1;
        @(posedge clock); #1;
        cnt_clear = 1'b0;
        exp_count = 0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        req_valid = 0; req_cond = 0; req_target = 0; res_ready = 0; cnt_clear = 0;
        flag_wr_en = 0; flag_wr_mask = 0; flag_wr_data = 0;
        repeat (3) @(posedge clock);
        #1;
        tests++;
        if ({req_ready, flag_rd_en, res_valid, res_taken} !== 4'b0000 || res_target !== '0 || taken_count !== '0) begin
            fails++;
            $display("FAIL reset_state: rdy=%0b rd=%0b vld=%0b tkn=%0b tgt=%h cnt=%0d required all 0",
                     req_ready, flag_rd_en, res_valid, res_taken, res_target, taken_count);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++; $display("FAIL reset_release_ready: %0b required 1", req_ready);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_basic;
        int lat;
        set_flags(4'b0001);
        send(4'h1, 16'h1234, lat);
        tests++;
        if (lat !== BASE_LAT || res_taken !== 1'b1 || res_target !== 16'h1234) begin
            fails++;
            $display("FAIL basic_z: lat=%0d tkn=%0b tgt=%h required lat=%0d tkn=1 tgt=1234",
                     lat, res_taken, res_target, BASE_LAT);
        end
        complete(1'b1, 0);
        tests++;
        if (taken_count !== CNT_W'(exp_count) || exp_count != 1) begin
            fails++; $display("FAIL basic_count: %0d required 1", taken_count);
        end
        $display("[TB] basic cond=1 lat=%0d taken=%0b count=%0d", lat, res_taken, taken_count);
    endtask

    task automatic test_sign_overflow;
        int lat;
        set_flags(4'b0100);
        send(4'h9, 16'h0009, lat);
        tests++;
        if (res_taken !== 1'b0 || lat !== BASE_LAT) begin
            fails++; $display("FAIL so_cond9: tkn=%0b lat=%0d required tkn=0 lat=%0d", res_taken, lat, BASE_LAT);
        end
        complete(1'b0, 0);
        send(4'hA, 16'h000A, lat);
        tests++;
        if (res_taken !== 1'b1 || lat !== BASE_LAT) begin
            fails++; $display("FAIL so_condA: tkn=%0b lat=%0d required tkn=1 lat=%0d", res_taken, lat, BASE_LAT);
        end
        complete(1'b1, 0);
        tests++;
        if (taken_count !== CNT_W'(exp_count) || exp_count != 2) begin
            fails++; $display("FAIL so_count: %0d required 2", taken_count);
        end
        $display("[TB] S!=O pair count=%0d", taken_count);
    endtask

    task automatic test_resp_stall;
        int lat;
        int bad = 0;
        send(4'h0, 16'hBEEF, lat);
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (res_valid !== 1'b1 || res_taken !== 1'b1 || res_target !== 16'hBEEF ||
                req_ready !== 1'b0 || taken_count !== CNT_W'(exp_count)) begin
                fails++; bad++;
                $display("FAIL stall_hold[%0d]: vld=%0b tkn=%0b tgt=%h rdy=%0b cnt=%0d required 1 1 beef 0 %0d",
                         i, res_valid, res_taken, res_target, req_ready, taken_count, exp_count);
            end
            @(posedge clock); #1;
        end
        complete(1'b1, 0);
        tests++;
        if (taken_count !== CNT_W'(exp_count) || res_valid !== 1'b0) begin
            fails++; $display("FAIL stall_release: cnt=%0d vld=%0b required %0d 0", taken_count, res_valid, exp_count);
        end
        $display("[TB] resp stall 5 cycles, hold errors=%0d", bad);
    endtask

    task automatic test_capture_write;
        int lat;
        set_flags(4'b0000);
        req_valid = 1'b1; req_cond = 4'h1; req_target = 16'h0C0D;
        @(posedge clock); #1;               // accept edge
        req_valid = 1'b0;
        @(posedge clock); #1;               // now in CAPTURE
        flag_wr_en = 1'b1; flag_wr_mask = 4'b0001; flag_wr_data = 4'b0001;
        @(posedge clock); #1;
        flag_wr_en = 1'b0; flag_wr_mask = 4'h0; flag_wr_data = 4'h0;
        lat = 2;
        while (!res_valid && lat < 40) begin @(posedge clock); #1; lat++; end
        tests++;
        if (lat !== BASE_LAT + HIT_EXTRA || res_taken !== 1'b1 || res_target !== 16'h0C0D) begin
            fails++;
            $display("FAIL capture_write: lat=%0d tkn=%0b tgt=%h required lat=%0d tkn=1 tgt=0c0d",
                     lat, res_taken, res_target, BASE_LAT + HIT_EXTRA);
        end
        complete(1'b1, 0);
        $display("[TB] write during capture lat=%0d taken=%0b", lat, res_taken);
    endtask

    task automatic test_random;
        int lat;
        logic [3:0] f, c;
        logic [ADDR_W-1:0] t;
        logic exp;
        clear_count();
        for (int i = 0; i < 40; i++) begin
            f = 4'($urandom); c = 4'($urandom); t = ADDR_W'($urandom);
            set_flags(f);
            send(c, t, lat);
            exp = ref_taken(c, f);
            tests++;
            if (lat !== BASE_LAT || res_taken !== exp || res_target !== t) begin
                fails++;
                $display("FAIL rand_result[%0d]: f=%b c=%h lat=%0d tkn=%0b tgt=%h required lat=%0d tkn=%0b tgt=%h",
                         i, f, c, lat, res_taken, res_target, BASE_LAT, exp, t);
            end
            complete(exp, $urandom_range(0, 3));
            tests++;
            if (taken_count !== CNT_W'(exp_count)) begin
                fails++; $display("FAIL rand_count[%0d]: %0d required %0d", i, taken_count, exp_count);
            end
            $display("[TB] rand %0d flags=%b cond=%h taken=%0b count=%0d", i, f, c, res_taken, taken_count);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        send(4'h0, 16'h5555, lat);
        complete(1'b1, 0);
        req_valid = 1'b1; req_cond = 4'h0; req_target = 16'hAAAA;
        @(posedge clock); #1;               // accept edge
        req_valid = 1'b0;
        @(posedge clock); #1;               // CAPTURE
        reset = 1'b0;
        #1;
        exp_count = 0;
        tests++;
        if (res_valid !== 1'b0 || req_ready !== 1'b0 || taken_count !== '0 || flag_rd_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: vld=%0b rdy=%0b cnt=%0d rd=%0b required 0 0 0 0",
                     res_valid, req_ready, taken_count, flag_rd_en);
        end
        @(posedge clock); #2;
        reset = 1'b1;
        @(posedge clock); #1;
        tests++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || taken_count !== '0) begin
            fails++;
            $display("FAIL reset_mid_release: rdy=%0b vld=%0b cnt=%0d required 1 0 0", req_ready, res_valid, taken_count);
        end
        $display("[TB] async reset in capture");
    endtask

    task automatic test_saturate;
        int lat;
        clear_count();
        for (int i = 0; i < CNT_MAX + 1; i++) begin
            send(4'h0, ADDR_W'(i), lat);
            complete(1'b1, 0);
        end
        tests++;
        if (taken_count !== CNT_W'(CNT_MAX) || exp_count != CNT_MAX) begin
            fails++; $display("FAIL saturate: %0d required %0d", taken_count, CNT_MAX);
        end
        send(4'h0, 16'h7777, lat);
        res_ready = 1'b1; cnt_clear = 1'b1;
        @(posedge clock); #1;
        res_ready = 1'b0; cnt_clear = 1'b0;
        exp_count = 0;
        tests++;
        if (taken_count !== '0 || res_valid !== 1'b0) begin
            fails++; $display("FAIL clear_priority: cnt=%0d vld=%0b required 0 0", taken_count, res_valid);
        end
        $display("[TB] saturation and clear priority count=%0d", taken_count);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign_overflow();
        test_resp_stall();
        test_capture_write();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
